// File: rtl/udma_i2s_slave_tx_if.sv
// TX word stream from the uDMA TX DC-FIFO into the I2S slave transmitter.
interface udma_i2s_slave_tx_if;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;

    modport master (output data, output data_valid, input data_ready);
    modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/udma_i2s_slave_tx.sv
// I2S slave transmitter: SCK/WS come from an external master, words arrive
// from the uDMA TX stream and are shifted out on pad_sd_o, oversampled in clk_i.
module udma_i2s_slave_tx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_en_i,
    input  logic               cfg_lsb_first_i,
    input  logic               cfg_2ch_i,
    input  logic [4:0]         cfg_bits_word_i,
    input  logic               cfg_clr_underrun_i,
    udma_i2s_slave_tx_if.slave tx,
    input  logic               pad_sck_i,
    input  logic               pad_ws_i,
    output logic               pad_sd_o,
    output logic               underrun_o
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        SHIFT     = 2'd2,
        PAD       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] ws_sync_r;
    logic                   sck_s;
    logic                   ws_s;
    logic                   sck_prev_r;
    logic                   sck_rise_s;
    logic                   sck_fall_s;
    logic                   ws_cur_r;
    logic                   ws_last_r;
    logic                   slot_start_s;
    logic                   active_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [31:0]            buf_r;
    logic                   buf_full_r;
    logic                   buf_full_nxt_s;
    logic                   ready_r;
    logic                   push_s;
    logic                   pop_s;
    logic                   load_s;
    logic [31:0]            shift_r;
    logic [31:0]            shift_nxt_s;
    logic [5:0]             bit_cnt_r;
    logic [5:0]             bit_cnt_nxt_s;
    logic [5:0]             nbits_s;
    logic [4:0]             bits_r;
    logic [4:0]             bits_nxt_s;
    logic                   lsb_r;
    logic                   lsb_nxt_s;
    logic                   sd_r;
    logic                   sd_nxt_s;
    logic                   underrun_r;
    logic                   underrun_set_s;

    assign sck_s        = sck_sync_r[SYNC_STAGES-1];
    assign ws_s         = ws_sync_r[SYNC_STAGES-1];
    assign sck_rise_s   = sck_s & ~sck_prev_r;
    assign sck_fall_s   = ~sck_s & sck_prev_r;
    // A WS change seen at a rise is pending until the following fall (I2S one-bit delay).
    assign slot_start_s = ws_cur_r ^ ws_last_r;
    assign active_s     = ~ws_cur_r | cfg_2ch_i;
    assign nbits_s      = {1'b0, bits_r} + 6'd1;
    assign push_s       = tx.data_valid & ready_r;

    assign tx.data_ready = ready_r;
    assign pad_sd_o      = sd_r;
    assign underrun_o    = underrun_r;

    // Pad synchronizers, edge detection and WS tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_r <= '0;
            ws_sync_r  <= '0;
            sck_prev_r <= 1'b0;
            ws_cur_r   <= 1'b0;
            ws_last_r  <= 1'b0;
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], pad_sck_i};
            ws_sync_r  <= {ws_sync_r[SYNC_STAGES-2:0], pad_ws_i};
            sck_prev_r <= sck_s;
            if (sck_rise_s) begin
                ws_cur_r  <= ws_s;
                ws_last_r <= ws_cur_r;
            end else begin
                ws_cur_r  <= ws_cur_r;
                ws_last_r <= ws_last_r;
            end
        end
    end

    // Next-state, serial data and slot-load decisions.
    always_comb begin
        state_nxt_s    = state_r;
        shift_nxt_s    = shift_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        bits_nxt_s     = bits_r;
        lsb_nxt_s      = lsb_r;
        sd_nxt_s       = sd_r;
        pop_s          = 1'b0;
        load_s         = 1'b0;
        underrun_set_s = 1'b0;
        if (!cfg_en_i) begin
            state_nxt_s   = IDLE;
            sd_nxt_s      = 1'b0;
            bit_cnt_nxt_s = 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    sd_nxt_s    = 1'b0;
                    state_nxt_s = WAIT_SYNC;
                end
                WAIT_SYNC: begin
                    sd_nxt_s = 1'b0;
                    load_s   = sck_fall_s & slot_start_s & ~ws_cur_r;
                end
                SHIFT: begin
                    load_s = sck_fall_s & slot_start_s;
                    if (sck_fall_s) begin
                        sd_nxt_s      = lsb_r ? shift_r[0] : shift_r[31];
                        shift_nxt_s   = lsb_r ? (shift_r >> 1) : (shift_r << 1);
                        bit_cnt_nxt_s = bit_cnt_r + 6'd1;
                        if ((bit_cnt_r + 6'd1) == nbits_s) begin
                            state_nxt_s = PAD;
                        end else begin
                            state_nxt_s = SHIFT;
                        end
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end
                PAD: begin
                    load_s = sck_fall_s & slot_start_s;
                    if (sck_fall_s) begin
                        sd_nxt_s = 1'b0;
                    end else begin
                        sd_nxt_s = sd_r;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    sd_nxt_s    = 1'b0;
                end
            endcase
            // A slot load overrides whatever the current slot was doing (truncation).
            if (load_s) begin
                bits_nxt_s = cfg_bits_word_i;
                lsb_nxt_s  = cfg_lsb_first_i;
                if (active_s && buf_full_r) begin
                    pop_s         = 1'b1;
                    sd_nxt_s      = cfg_lsb_first_i ? buf_r[0] : buf_r[cfg_bits_word_i];
                    shift_nxt_s   = cfg_lsb_first_i ? (buf_r >> 1)
                                                    : (buf_r << (6'd32 - {1'b0, cfg_bits_word_i}));
                    bit_cnt_nxt_s = 6'd1;
                    state_nxt_s   = (cfg_bits_word_i == 5'd0) ? PAD : SHIFT;
                end else begin
                    sd_nxt_s       = 1'b0;
                    bit_cnt_nxt_s  = 6'd0;
                    state_nxt_s    = PAD;
                    underrun_set_s = active_s;
                end
            end else begin
                bits_nxt_s = bits_r;
            end
        end
    end

    // Holding register occupancy: disable flushes, pop frees, push fills.
    always_comb begin
        buf_full_nxt_s = buf_full_r;
        if (!cfg_en_i) begin
            buf_full_nxt_s = 1'b0;
        end else if (pop_s) begin
            buf_full_nxt_s = 1'b0;
        end else if (push_s) begin
            buf_full_nxt_s = 1'b1;
        end else begin
            buf_full_nxt_s = buf_full_r;
        end
    end

    // Transmit datapath and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            buf_r      <= 32'd0;
            buf_full_r <= 1'b0;
            ready_r    <= 1'b0;
            shift_r    <= 32'd0;
            bit_cnt_r  <= 6'd0;
            bits_r     <= 5'd0;
            lsb_r      <= 1'b0;
            sd_r       <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            buf_full_r <= buf_full_nxt_s;
            ready_r    <= cfg_en_i & ~buf_full_nxt_s;
            if (push_s) begin
                buf_r <= tx.data;
            end else begin
                buf_r <= buf_r;
            end
            shift_r    <= shift_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            bits_r     <= bits_nxt_s;
            lsb_r      <= lsb_nxt_s;
            sd_r       <= sd_nxt_s;
            if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end else if (cfg_clr_underrun_i) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end
endmodule

// File: tb/tb_udma_i2s_slave_tx.sv
// Self-checking bench for udma_i2s_slave_tx: the bench acts as the external I2S
// master (SCK = 8 clk, 32-SCK slots) and as the uDMA word source.
module tb_udma_i2s_slave_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_en;
    logic       cfg_lsb;
    logic       cfg_2ch;
    logic [4:0] cfg_bits;
    logic       clr;
    logic       sck;
    logic       ws;
    logic       sd;
    logic       und;

    udma_i2s_slave_tx_if bus ();

    udma_i2s_slave_tx #(.SYNC_STAGES(2)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cfg_en_i           (cfg_en),
        .cfg_lsb_first_i    (cfg_lsb),
        .cfg_2ch_i          (cfg_2ch),
        .cfg_bits_word_i    (cfg_bits),
        .cfg_clr_underrun_i (clr),
        .tx                 (bus.slave),
        .pad_sck_i          (sck),
        .pad_ws_i           (ws),
        .pad_sd_o           (sd),
        .underrun_o         (und)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] words [0:15];
    int          feed_n   = 0;
    int          feed_idx = 0;
    logic [31:0] got [0:7];

    typedef struct {
        logic [4:0]  bits;
        logic        lsb;
        logic        ch2;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
        logic        exp_und;
    } vec_t;
    vec_t tbl [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word source: offers the next queued word whenever the DUT reports ready.
    initial begin
        bus.data       = 32'd0;
        bus.data_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (feed_idx < feed_n && bus.data_ready === 1'b1) begin
                bus.data       = words[feed_idx];
                bus.data_valid = 1'b1;
                feed_idx++;
            end else begin
                bus.data_valid = 1'b0;
            end
        end
    end

    // One SCK period: fall (WS changes here), optional clear pulse aligned with the
    // synced fall strobe, sample SD late in the low phase, then the high phase.
    task automatic sck_cycle(input logic ws_v, input logic do_clr, output logic s);
        @(negedge clk);
        sck = 1'b0;
        ws  = ws_v;
        @(negedge clk);
        @(negedge clk);
        clr = do_clr;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        s   = sd;
        sck = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic prep(input logic [4:0] b, input logic l, input logic c2, input int nw);
        logic s;
        @(negedge clk);
        feed_n   = 0;
        cfg_en   = 1'b0;
        cfg_bits = b;
        cfg_lsb  = l;
        cfg_2ch  = c2;
        clr      = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        sck_cycle(1'b1, 1'b0, s);
        sck_cycle(1'b1, 1'b0, s);
        feed_idx = 0;
        feed_n   = nw;
        cfg_en   = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Collect whole slots; slot 2f = left of frame f, 2f+1 = right of frame f.
    task automatic run_frames(input int nf);
        logic s;
        for (int f = 0; f < nf; f++) begin
            for (int c = 0; c < 64; c++) begin
                sck_cycle((c >= 32) ? 1'b1 : 1'b0, 1'b0, s);
                if (c >= 1 && c <= 32)  got[2*f]   = {got[2*f][30:0], s};
                else if (c >= 33)       got[2*f+1] = {got[2*f+1][30:0], s};
                else if (f > 0)         got[2*f-1] = {got[2*f-1][30:0], s};
            end
        end
        sck_cycle(1'b0, 1'b0, s);
        got[2*nf-1] = {got[2*nf-1][30:0], s};
    endtask

    // Reference: slot content as seen on the wire, first bit in [31].
    function automatic logic [31:0] slot_bits(input logic [31:0] w, input int nbits, input logic lsb_f);
        logic [31:0] v;
        v = 32'd0;
        for (int p = 0; p < nbits; p++) v[31-p] = lsb_f ? w[p] : w[nbits-1-p];
        return v;
    endfunction

    initial begin
        logic        s;
        logic        acc;
        logic [31:0] v;
        logic [31:0] w;
        int          nw;
        int          k;
        logic        exp_und;
        logic        active;

        tbl[0] = '{5'd15, 1'b0, 1'b1, 2, 32'h0000A5C3, 32'h00001234, 32'hA5C30000, 32'h12340000, 1'b0};
        tbl[1] = '{5'd7,  1'b1, 1'b1, 2, 32'h00000001, 32'h00000080, 32'h80000000, 32'h01000000, 1'b0};
        tbl[2] = '{5'd23, 1'b0, 1'b0, 1, 32'h00ABCDEF, 32'h0,        32'hABCDEF00, 32'h00000000, 1'b0};
        tbl[3] = '{5'd31, 1'b0, 1'b1, 1, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h00000000, 1'b1};
        tbl[4] = '{5'd0,  1'b0, 1'b1, 2, 32'h00000001, 32'hFFFFFFFE, 32'h80000000, 32'h00000000, 1'b0};
        tbl[5] = '{5'd31, 1'b1, 1'b1, 2, 32'h00000001, 32'h80000000, 32'h80000000, 32'h00000001, 1'b0};
        tbl[6] = '{5'd15, 1'b0, 1'b1, 0, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 1'b1};
        tbl[7] = '{5'd15, 1'b0, 1'b1, 2, 32'hFFFF0001, 32'h5A5A0000, 32'h00010000, 32'h00000000, 1'b0};

        rst = 1'b1; cfg_en = 1'b1; cfg_lsb = 1'b0; cfg_2ch = 1'b1; cfg_bits = 5'd15;
        clr = 1'b0; sck = 1'b1; ws = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_sd",    {31'd0, sd},             32'd0);
        check("reset_ready", {31'd0, bus.data_ready}, 32'd0);
        check("reset_und",   {31'd0, und},            32'd0);
        rst = 1'b0; cfg_en = 1'b0;

        // Directed frame vectors.
        for (int i = 0; i < 8; i++) begin
            words[0] = tbl[i].w0;
            words[1] = tbl[i].w1;
            prep(tbl[i].bits, tbl[i].lsb, tbl[i].ch2, tbl[i].nw);
            run_frames(1);
            check($sformatf("tbl%0d_left", i),  got[0], tbl[i].exp_l);
            check($sformatf("tbl%0d_right", i), got[1], tbl[i].exp_r);
            check($sformatf("tbl%0d_und", i),   {31'd0, und}, {31'd0, tbl[i].exp_und});
        end

        // Randomized configurations against the slot-level reference.
        for (int r = 0; r < 6; r++) begin
            nw = $urandom_range(5, 0);
            for (int j = 0; j < 6; j++) words[j] = $urandom();
            prep(5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), nw);
            run_frames(2);
            k = 0;
            exp_und = 1'b0;
            for (int sl = 0; sl < 4; sl++) begin
                active = ((sl % 2) == 0) || cfg_2ch;
                v = 32'd0;
                if (active && k < nw) begin
                    v = slot_bits(words[k], int'(cfg_bits) + 1, cfg_lsb);
                    k++;
                end else if (active) begin
                    exp_und = 1'b1;
                end
                check($sformatf("rnd%0d_slot%0d", r, sl), got[sl], v);
            end
            check($sformatf("rnd%0d_und", r), {31'd0, und}, {31'd0, exp_und});
        end

        // Underrun clear, and clear colliding with a new underrun.
        prep(5'd15, 1'b0, 1'b1, 0);
        sck_cycle(1'b0, 1'b0, s);
        sck_cycle(1'b0, 1'b1, s);
        check("und_set_beats_clr", {31'd0, und}, 32'd1);
        sck_cycle(1'b0, 1'b1, s);
        check("und_clr", {31'd0, und}, 32'd0);
        acc = 1'b0;
        for (int c = 3; c < 34; c++) begin
            sck_cycle((c >= 32) ? 1'b1 : 1'b0, 1'b0, s);
            acc = acc | s;
        end
        check("und_right_sticky", {31'd0, und}, 32'd1);
        check("und_slot_zero",    {31'd0, acc}, 32'd0);

        // Enable mid-frame while WS is high, 1ch 24-bit.
        @(negedge clk);
        feed_n = 0; cfg_en = 1'b0; cfg_bits = 5'd23; cfg_lsb = 1'b0; cfg_2ch = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int c = 29; c < 40; c++) sck_cycle((c >= 32) ? 1'b1 : 1'b0, 1'b0, s);
        w = $urandom();
        words[0] = w; feed_idx = 0; feed_n = 1; cfg_en = 1'b1;
        acc = 1'b0;
        for (int c = 40; c < 64; c++) begin
            sck_cycle(1'b1, 1'b0, s);
            acc = acc | s;
        end
        check("late_en_quiet",  {31'd0, acc},            32'd0);
        check("late_en_no_und", {31'd0, und},            32'd0);
        check("late_en_full",   {31'd0, bus.data_ready}, 32'd0);
        acc = 1'b0;
        for (int c = 0; c < 64; c++) begin
            sck_cycle((c >= 32) ? 1'b1 : 1'b0, 1'b0, s);
            if (c >= 1 && c <= 32) got[0] = {got[0][30:0], s};
            else if (c >= 33)      acc = acc | s;
            if (c == 2) check("ready_after_pop", {31'd0, bus.data_ready}, 32'd1);
        end
        check("late_en_word",  got[0], {w[23:0], 8'd0});
        check("1ch_right_zero", {31'd0, acc}, 32'd0);
        check("1ch_no_und",    {31'd0, und}, 32'd0);

        // Disable after 5 bits of a 32-bit word, flush, re-enable.
        words[0] = 32'hFFFFFFFF; words[1] = 32'h12345678;
        prep(5'd31, 1'b0, 1'b1, 2);
        v = 32'd0;
        for (int c = 0; c < 6; c++) begin
            sck_cycle(1'b0, 1'b0, s);
            if (c >= 1) v = {v[30:0], s};
        end
        check("pre_dis_bits", v, 32'h1F);
        @(negedge clk);
        feed_n = 0; cfg_en = 1'b0;
        @(negedge clk);
        check("dis_sd_next_clk", {31'd0, sd},             32'd0);
        check("dis_ready",       {31'd0, bus.data_ready}, 32'd0);
        cfg_en = 1'b1;
        repeat (2) @(negedge clk);
        check("flush_ready", {31'd0, bus.data_ready}, 32'd1);
        words[0] = 32'hC0000001; feed_idx = 0; feed_n = 1;
        acc = 1'b0;
        for (int c = 6; c < 64; c++) begin
            sck_cycle((c >= 32) ? 1'b1 : 1'b0, 1'b0, s);
            acc = acc | s;
        end
        check("reen_wait_quiet", {31'd0, acc}, 32'd0);
        check("reen_wait_und",   {31'd0, und}, 32'd0);
        for (int c = 0; c < 33; c++) begin
            sck_cycle((c >= 32) ? 1'b1 : 1'b0, 1'b0, s);
            if (c >= 1) got[0] = {got[0][30:0], s};
        end
        check("reen_left_word", got[0], 32'hC0000001);
        check("reen_no_und",    {31'd0, und}, 32'd0);

        // Synchronous reset in the middle of a word.
        words[0] = 32'h0000FFFF;
        prep(5'd15, 1'b0, 1'b1, 1);
        for (int c = 0; c < 41; c++) sck_cycle((c >= 32) ? 1'b1 : 1'b0, 1'b0, s);
        check("rst_pre_und", {31'd0, und}, 32'd1);
        words[1] = 32'h0000FFFF; feed_n = 2;
        for (int c = 41; c < 64; c++) sck_cycle(1'b1, 1'b0, s);
        for (int c = 0; c < 4; c++)   sck_cycle(1'b0, 1'b0, s);
        check("rst_pre_sd", {31'd0, sd}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_sd",    {31'd0, sd},             32'd0);
        check("rst_mid_und",   {31'd0, und},            32'd0);
        check("rst_mid_ready", {31'd0, bus.data_ready}, 32'd0);
        rst = 1'b0; cfg_en = 1'b0; feed_n = 0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
